// File: rtl/rect_pkg.sv
// Shared types and default raster constants for the rectangle sprite objects.
// Holds the motion FSM state enum, the axis direction type and the default
// visible-area sizes used as parameter defaults by the sprite modules.
package rect_pkg;

    typedef enum logic [1:0] {
        HOLD,
        RUN,
        HOMING
    } state_t;

    typedef enum logic {
        POS = 1'b0,
        NEG = 1'b1
    } dir_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

endpackage

// File: rtl/object_rectangle_motion_if.sv
// Raster/control/result bundle between the VGA sync counter, the rectangle
// sprite and the colour mux.
// master: drives HCount, VCount, rectangle_select, full_screen, move_en, home
//         and receives rectangle_on, rect_x, rect_y, bounce.
// slave : the sprite side, the mirror image of master.
interface object_rectangle_motion_if #(
    parameter int COORD_W = 10
);

    logic [COORD_W-1:0] HCount;
    logic [COORD_W-1:0] VCount;
    logic               rectangle_select;
    logic               full_screen;
    logic               move_en;
    logic               home;
    logic               rectangle_on;
    logic [COORD_W-1:0] rect_x;
    logic [COORD_W-1:0] rect_y;
    logic               bounce;

    modport master (
        output HCount, VCount, rectangle_select, full_screen, move_en, home,
        input  rectangle_on, rect_x, rect_y, bounce
    );

    modport slave (
        input  HCount, VCount, rectangle_select, full_screen, move_en, home,
        output rectangle_on, rect_x, rect_y, bounce
    );

endinterface

// File: rtl/frame_tick_gen.sv
// One-cycle-per-frame tick, raised on the first clock the raster reaches
// (0, V_ACTIVE). Ports: clk, reset (async, active-high), hcount, vcount, tick.
module frame_tick_gen #(
    parameter int COORD_W  = 10,
    parameter int V_ACTIVE = 480
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] hcount,
    input  logic [COORD_W-1:0] vcount,
    output logic               tick
);

    logic cond;
    logic cond_q;

    assign cond = (hcount == '0) && (vcount == COORD_W'(V_ACTIVE));

    // Edge detect keeps the tick to one cycle however long the raster dwells.
    // Resetting to 1 suppresses a tick if reset releases at the tick point.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cond_q <= 1'b1;
        else       cond_q <= cond;
    end

    assign tick = cond & ~cond_q;

endmodule

// File: rtl/object_rectangle_motion.sv
// Moving VGA rectangle: registered pixel enable from the raster plus a
// per-frame position FSM (HOLD / RUN / HOMING) with wall bounce.
// Ports: clk, reset (async, active-high), bus (slave side of
// object_rectangle_motion_if). Optional build macro RECT_BLINK_EN blinks
// the rectangle while it is held.
module object_rectangle_motion
    import rect_pkg::*;
#(
    parameter int COORD_W      = 10,
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int V_ACTIVE     = V_ACTIVE_DEF,
    parameter int RECT_W       = 160,
    parameter int RECT_H       = 115,
    parameter int X_INIT       = 240,
    parameter int Y_INIT       = 178,
    parameter int STEP         = 2,
    parameter int BLINK_FRAMES = 30
) (
    input logic                      clk,
    input logic                      reset,
    object_rectangle_motion_if.slave bus
);

    localparam int X_MAX = H_ACTIVE - RECT_W;
    localparam int Y_MAX = V_ACTIVE - RECT_H;
    localparam int CW1   = COORD_W + 1;
    localparam int SW    = COORD_W + 2;

    localparam logic signed [SW-1:0] ZERO_S = '0;
    localparam logic signed [SW-1:0] STEP_S = SW'(STEP);
    localparam logic signed [SW-1:0] XMAX_S = SW'(X_MAX);
    localparam logic signed [SW-1:0] YMAX_S = SW'(Y_MAX);

    if (RECT_W > H_ACTIVE || RECT_H > V_ACTIVE ||
        X_INIT > X_MAX || Y_INIT > Y_MAX ||
        STEP < 1 || STEP > X_MAX || STEP > Y_MAX ||
        BLINK_FRAMES < 1) begin : g_param_err
        $error("object_rectangle_motion: illegal parameters");
    end

    state_t             state_q, state_d;
    dir_t               dx_q, dx_d, dy_q, dy_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               flip;
    logic               bounce_q;
    logic               on_q, on_d;
    logic               tick;
    logic               hit;
    logic               blink_ok;
    logic [COORD_W:0]   mv_x, mv_y;

    frame_tick_gen #(
        .COORD_W  (COORD_W),
        .V_ACTIVE (V_ACTIVE)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .hcount (bus.HCount),
        .vcount (bus.VCount),
        .tick   (tick)
    );

    // Hit test one bit wider than the raster so right/bottom edges never wrap.
    logic [CW1-1:0] hc_e, vc_e, x_l, x_r, y_t, y_b;

    assign hc_e = {1'b0, bus.HCount};
    assign vc_e = {1'b0, bus.VCount};
    assign x_l  = {1'b0, x_q};
    assign y_t  = {1'b0, y_q};
    assign x_r  = x_l + CW1'(RECT_W - 1);
    assign y_b  = y_t + CW1'(RECT_H - 1);
    assign hit  = (hc_e >= x_l) && (hc_e <= x_r) &&
                  (vc_e >= y_t) && (vc_e <= y_b);

    // Returns {dir, pos}; reaching or passing a wall clamps and points back.
    function automatic logic [COORD_W:0] advance(
        input logic [COORD_W-1:0]   p,
        input dir_t                 d,
        input logic signed [SW-1:0] mx
    );
        logic signed [SW-1:0] n;
        n = (d == POS) ? $signed({2'b00, p}) + STEP_S
                       : $signed({2'b00, p}) - STEP_S;
        if (n <= ZERO_S)  return {1'b0, COORD_W'(0)};
        else if (n >= mx) return {1'b1, mx[COORD_W-1:0]};
        else              return {d, n[COORD_W-1:0]};
    endfunction

    assign mv_x = advance(x_q, dx_q, XMAX_S);
    assign mv_y = advance(y_q, dy_q, YMAX_S);

    always_comb begin
        state_d = state_q;
        case (state_q)
            HOLD:    if (bus.move_en) state_d = RUN;
            RUN:     if (!bus.move_en) state_d = HOLD;
            HOMING:  if (tick) state_d = bus.move_en ? RUN : HOLD;
            default: state_d = HOLD;
        endcase
        if (bus.home) state_d = HOMING;
    end

    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        dx_d = dx_q;
        dy_d = dy_q;
        flip = 1'b0;
        if (tick) begin
            case (state_q)
                RUN: begin
                    x_d  = mv_x[COORD_W-1:0];
                    y_d  = mv_y[COORD_W-1:0];
                    dx_d = dir_t'(mv_x[COORD_W]);
                    dy_d = dir_t'(mv_y[COORD_W]);
                    flip = (dx_d != dx_q) || (dy_d != dy_q);
                end
                HOMING: begin
                    x_d  = COORD_W'(X_INIT);
                    y_d  = COORD_W'(Y_INIT);
                    dx_d = POS;
                    dy_d = POS;
                end
                default: ;
            endcase
        end
    end

`ifdef RECT_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BW-1:0] blink_cnt;
    logic          blink_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_q   <= 1'b1;
        end else if (state_q != HOLD) begin
            blink_cnt <= '0;
            blink_q   <= 1'b1;
        end else if (tick) begin
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                blink_q   <= ~blink_q;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign blink_ok = (state_q != HOLD) | blink_q;
`else
    assign blink_ok = 1'b1;
`endif

    assign on_d = hit & ~(bus.full_screen & ~bus.rectangle_select) & blink_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= HOLD;
            x_q      <= COORD_W'(X_INIT);
            y_q      <= COORD_W'(Y_INIT);
            dx_q     <= POS;
            dy_q     <= POS;
            bounce_q <= 1'b0;
            on_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            bounce_q <= flip;
            on_q     <= on_d;
        end
    end

    assign bus.rectangle_on = on_q;
    assign bus.rect_x       = x_q;
    assign bus.rect_y       = y_q;
    assign bus.bounce       = bounce_q;

endmodule

// File: tb/tb_object_rectangle_motion.sv
// Directed bench for object_rectangle_motion: a default instance and one
// homed next to the bottom-right corner, sharing clock, reset and raster.
module tb_object_rectangle_motion;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    object_rectangle_motion_if #(.COORD_W(10)) bus0 ();
    object_rectangle_motion_if #(.COORD_W(10)) bus1 ();

    object_rectangle_motion dut0 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus0)
    );

    object_rectangle_motion #(
        .X_INIT (478),
        .Y_INIT (363)
    ) dut1 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus1)
    );

    int n_checks = 0;
    int n_errors = 0;
    int b0_cnt   = 0;
    int b1_cnt   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic raster(input int h, input int v);
        bus0.HCount = 10'(h);
        bus0.VCount = 10'(v);
        bus1.HCount = 10'(h);
        bus1.VCount = 10'(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        b0_cnt += int'(bus0.bounce);
        b1_cnt += int'(bus1.bounce);
    endtask

    task automatic frame_tick();
        raster(0, 480);
        step();
        raster(5, 10);
        step();
    endtask

    initial begin
        rst = 1'b1;
        raster(0, 480);
        bus0.rectangle_select = 1'b0;
        bus0.full_screen      = 1'b0;
        bus0.move_en          = 1'b0;
        bus0.home             = 1'b0;
        bus1.rectangle_select = 1'b0;
        bus1.full_screen      = 1'b0;
        bus1.move_en          = 1'b0;
        bus1.home             = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        chk("rst_x", 32'(bus0.rect_x), 240);
        chk("rst_y", 32'(bus0.rect_y), 178);
        chk("rst_on", 32'(bus0.rectangle_on), 0);
        chk("rst_bounce", 32'(bus0.bounce), 0);
        chk("rst_x1", 32'(bus1.rect_x), 478);
        chk("rst_y1", 32'(bus1.rect_y), 363);

        rst = 1'b0;
        repeat (3) step();
        chk("release_x", 32'(bus0.rect_x), 240);

        raster(240, 178); step(); chk("hit_tl", 32'(bus0.rectangle_on), 1);
        raster(400, 178); step(); chk("miss_r", 32'(bus0.rectangle_on), 0);
        raster(399, 178); step(); chk("hit_r", 32'(bus0.rectangle_on), 1);
        raster(240, 293); step(); chk("miss_b", 32'(bus0.rectangle_on), 0);
        raster(240, 292); step(); chk("hit_b", 32'(bus0.rectangle_on), 1);
        raster(239, 178); step(); chk("miss_l", 32'(bus0.rectangle_on), 0);

        bus0.full_screen = 1'b1;
        raster(300, 200); step(); chk("fs_gate", 32'(bus0.rectangle_on), 0);
        bus0.rectangle_select = 1'b1;
        step(); chk("fs_sel", 32'(bus0.rectangle_on), 1);
        bus0.full_screen = 1'b0;
        bus0.rectangle_select = 1'b0;
        step(); chk("win_mode", 32'(bus0.rectangle_on), 1);

        b0_cnt = 0;
        bus0.move_en = 1'b1;
        step();
        repeat (10) frame_tick();
        chk("run10_x", 32'(bus0.rect_x), 260);
        chk("run10_y", 32'(bus0.rect_y), 198);
        chk("run10_bounce", 32'(b0_cnt), 0);

        bus0.move_en = 1'b0;
        step();
        repeat (5) frame_tick();
        chk("hold_x", 32'(bus0.rect_x), 260);
        chk("hold_y", 32'(bus0.rect_y), 198);

        b1_cnt = 0;
        bus1.move_en = 1'b1;
        step();
        raster(0, 480);
        step();
        chk("wall_x", 32'(bus1.rect_x), 480);
        chk("wall_y", 32'(bus1.rect_y), 365);
        chk("wall_bounce", 32'(bus1.bounce), 1);
        raster(5, 10);
        step();
        chk("bounce_one", 32'(bus1.bounce), 0);
        frame_tick();
        chk("back_x", 32'(bus1.rect_x), 478);
        chk("back_y", 32'(bus1.rect_y), 363);
        chk("bounce_cnt", 32'(b1_cnt), 1);
        bus1.move_en = 1'b0;

        bus0.move_en = 1'b1;
        step();
        repeat (20) frame_tick();
        chk("run20_x", 32'(bus0.rect_x), 300);
        chk("run20_y", 32'(bus0.rect_y), 238);

        bus0.home = 1'b1;
        step();
        bus0.home = 1'b0;
        chk("home_wait", 32'(bus0.rect_x), 300);
        frame_tick();
        chk("home_x", 32'(bus0.rect_x), 240);
        chk("home_y", 32'(bus0.rect_y), 178);
        frame_tick();
        chk("home_dx", 32'(bus0.rect_x), 242);
        chk("home_dy", 32'(bus0.rect_y), 180);

        bus0.home = 1'b1;
        raster(0, 480);
        step();
        bus0.home = 1'b0;
        chk("home_tick", 32'(bus0.rect_x), 244);
        raster(5, 10);
        step();
        frame_tick();
        chk("home_late", 32'(bus0.rect_x), 240);
        frame_tick();
        chk("rerun_x", 32'(bus0.rect_x), 242);

        raster(250, 190);
        step();
        chk("pre_rst_on", 32'(bus0.rectangle_on), 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_x", 32'(bus0.rect_x), 240);
        chk("mid_rst_y", 32'(bus0.rect_y), 178);
        chk("mid_rst_on", 32'(bus0.rectangle_on), 0);
        chk("mid_rst_b", 32'(bus0.bounce), 0);
        raster(0, 480);
        step();
        rst = 1'b0;
        repeat (3) step();
        chk("rel_no_tick", 32'(bus0.rect_x), 240);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
